// File: rtl/dbg_ctrl_pkg.sv
// Shared types and default constants for the debug-request controller.
package dbg_ctrl_pkg;

    localparam int unsigned DBG_TIMEOUT_DEF = 64;
    localparam int unsigned DBG_ADDR_W      = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        HALTED = 3'd2,
        RESUME = 3'd3,
        ERR    = 3'd4
    } dbg_state_e;

endpackage

// File: rtl/dbg_timeout_cnt.sv
// Loadable down-counter bounding how long the core may take to answer.
module dbg_timeout_cnt
    import dbg_ctrl_pkg::*;
#(
    parameter int unsigned LOAD_VAL = DBG_TIMEOUT_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned CNT_W = $clog2(LOAD_VAL + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CNT_W'(LOAD_VAL);
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Last waiting cycle: the controller gives up on this edge.
    assign expire_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/dbg_req_ctrl.sv
// Debug-request initiator: drives the core's debug request, captures the
// halt PC, issues the resume strobe and flags a core that never answers.
module dbg_req_ctrl
    import dbg_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DBG_TIMEOUT_DEF,
    parameter int unsigned ADDR_WIDTH     = DBG_ADDR_W
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  halt_req_i,
    input  logic                  resume_req_i,
    input  logic                  clear_i,
    input  logic                  core_debug_mode_i,
    input  logic [ADDR_WIDTH-1:0] core_instr_addr_i,
    output logic                  debug_req_o,
    output logic                  core_resume_o,
    output logic                  busy_o,
    output logic                  halted_o,
    output logic                  timeout_o,
    output logic [ADDR_WIDTH-1:0] halt_pc_o
);

    dbg_state_e            state_q;
    dbg_state_e            state_d;
    logic [ADDR_WIDTH-1:0] pc_d;
    logic                  cnt_load;
    logic                  cnt_en;
    logic                  cnt_expire;

    dbg_timeout_cnt #(
        .LOAD_VAL (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .load_i   (cnt_load),
        .en_i     (cnt_en),
        .expire_o (cnt_expire)
    );

    // Next-state logic; the counter is reloaded on every REQ/RESUME entry.
    always_comb begin
        state_d  = state_q;
        pc_d     = halt_pc_o;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (halt_req_i) begin
                    state_d  = REQ;
                    cnt_load = 1'b1;
                end
            end
            REQ: begin
                if (core_debug_mode_i) begin
                    state_d = HALTED;
                    pc_d    = core_instr_addr_i;
                end else if (cnt_expire) begin
                    state_d = ERR;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            HALTED: begin
                if (resume_req_i) begin
                    state_d  = RESUME;
                    cnt_load = 1'b1;
                end else if (!core_debug_mode_i) begin
                    state_d = IDLE;
                end
            end
            RESUME: begin
                if (!core_debug_mode_i) begin
                    state_d = IDLE;
                end else if (cnt_expire) begin
                    state_d = ERR;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ERR: begin
                if (clear_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they track it edge for edge.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            debug_req_o   <= 1'b0;
            core_resume_o <= 1'b0;
            busy_o        <= 1'b0;
            halted_o      <= 1'b0;
            timeout_o     <= 1'b0;
            halt_pc_o     <= '0;
        end else begin
            state_q       <= state_d;
            debug_req_o   <= (state_d == REQ);
            core_resume_o <= (state_q == HALTED) && (state_d == RESUME);
            busy_o        <= (state_d == REQ) || (state_d == RESUME);
            halted_o      <= (state_d == HALTED);
            timeout_o     <= (state_d == ERR);
            halt_pc_o     <= pc_d;
        end
    end

endmodule

// File: tb/tb_dbg_req_ctrl.sv
// Scoreboard bench for dbg_req_ctrl: each stimulus cycle queues the expected
// outputs after the next edge; a monitor pops and compares them.
module tb_dbg_req_ctrl;

    localparam int unsigned T_CYC  = 8;
    localparam int unsigned ADDR_W = 32;

    // Expected-output vector bits: {debug_req, core_resume, busy, halted, timeout}
    localparam logic [4:0] O_IDLE = 5'b00000;
    localparam logic [4:0] O_REQ  = 5'b10100;
    localparam logic [4:0] O_HLT  = 5'b00010;
    localparam logic [4:0] O_RSP  = 5'b01100;
    localparam logic [4:0] O_RES  = 5'b00100;
    localparam logic [4:0] O_ERR  = 5'b00001;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              halt_req;
    logic              resume_req;
    logic              clear;
    logic              dbg_mode;
    logic [ADDR_W-1:0] instr_addr;
    logic              debug_req;
    logic              core_resume;
    logic              busy;
    logic              halted;
    logic              timeout;
    logic [ADDR_W-1:0] halt_pc;

    int total = 0;
    int bad   = 0;

    logic [ADDR_W+4:0] exp_q[$];
    string             name_q[$];

    always #5 clk = ~clk;

    dbg_req_ctrl #(
        .TIMEOUT_CYCLES (T_CYC),
        .ADDR_WIDTH     (ADDR_W)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .halt_req_i        (halt_req),
        .resume_req_i      (resume_req),
        .clear_i           (clear),
        .core_debug_mode_i (dbg_mode),
        .core_instr_addr_i (instr_addr),
        .debug_req_o       (debug_req),
        .core_resume_o     (core_resume),
        .busy_o            (busy),
        .halted_o          (halted),
        .timeout_o         (timeout),
        .halt_pc_o         (halt_pc)
    );

    // Monitor: the DUT presents a new output word after every rising edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            logic [ADDR_W+4:0] exp_v;
            logic [ADDR_W+4:0] act_v;
            string             nm;
            exp_v = exp_q.pop_front();
            nm    = name_q.pop_front();
            act_v = {debug_req, core_resume, busy, halted, timeout, halt_pc};
            total++;
            if (act_v !== exp_v) begin
                bad++;
                $display("FAIL %s: got flags=%b pc=%h, want flags=%b pc=%h",
                         nm, act_v[ADDR_W+4:ADDR_W], act_v[ADDR_W-1:0],
                         exp_v[ADDR_W+4:ADDR_W], exp_v[ADDR_W-1:0]);
            end
        end
    end

    // Drive one cycle of inputs and queue the outputs expected after the edge.
    task automatic cyc(input string nm, input logic rst, input logic h, input logic r,
                       input logic c, input logic dm, input logic [ADDR_W-1:0] a,
                       input logic [4:0] e, input logic [ADDR_W-1:0] epc);
        @(negedge clk);
        rst_n      = rst;
        halt_req   = h;
        resume_req = r;
        clear      = c;
        dbg_mode   = dm;
        instr_addr = a;
        exp_q.push_back({e, epc});
        name_q.push_back(nm);
    endtask

    initial begin
        rst_n      = 1'b0;
        halt_req   = 1'b0;
        resume_req = 1'b0;
        clear      = 1'b0;
        dbg_mode   = 1'b0;
        instr_addr = '0;

        cyc("reset0", 0, 0, 0, 0, 0, 32'h0, O_IDLE, 32'h0);
        cyc("reset1", 0, 1, 1, 1, 1, 32'hdead, O_IDLE, 32'h0);

        // Normal halt: core answers on the third REQ cycle
        cyc("halt_req",  1, 1, 0, 0, 0, 32'h0,   O_REQ, 32'h0);
        cyc("req_wait1", 1, 0, 0, 0, 0, 32'h0,   O_REQ, 32'h0);
        cyc("req_wait2", 1, 0, 0, 0, 0, 32'h0,   O_REQ, 32'h0);
        cyc("halted",    1, 0, 0, 0, 1, 32'h120, O_HLT, 32'h120);
        cyc("halt_ign",  1, 1, 0, 0, 1, 32'h200, O_HLT, 32'h120);

        // Resume: core leaves debug mode two cycles after the strobe
        cyc("resume_strobe", 1, 0, 1, 0, 1, 32'h200, O_RSP,  32'h120);
        cyc("resume_wait",   1, 0, 0, 0, 1, 32'h200, O_RES,  32'h120);
        cyc("resume_done",   1, 0, 0, 0, 0, 32'h204, O_IDLE, 32'h120);
        cyc("idle_res_ign",  1, 0, 1, 0, 0, 32'h204, O_IDLE, 32'h120);

        // Halt timeout: debug_req for exactly T_CYC cycles, then sticky timeout
        cyc("to_req", 1, 1, 0, 0, 0, 32'h0, O_REQ, 32'h120);
        for (int i = 1; i < int'(T_CYC); i++)
            cyc("to_req_hold", 1, 0, 0, 0, 0, 32'h0, O_REQ, 32'h120);
        cyc("to_err",    1, 0, 0, 0, 0, 32'h0,  O_ERR,  32'h120);
        cyc("err_stick", 1, 1, 1, 0, 1, 32'h44, O_ERR,  32'h120);
        cyc("err_clear", 1, 0, 0, 1, 0, 32'h0,  O_IDLE, 32'h120);

        // Detection wins over timeout on the last waiting cycle
        cyc("edge_req", 1, 1, 0, 0, 0, 32'h0, O_REQ, 32'h120);
        for (int i = 1; i < int'(T_CYC); i++)
            cyc("edge_req_hold", 1, 0, 0, 0, 0, 32'h0, O_REQ, 32'h120);
        cyc("edge_detect", 1, 0, 0, 0, 1, 32'h77, O_HLT, 32'h77);
        cyc("core_drop",   1, 0, 0, 0, 0, 32'h80, O_IDLE, 32'h77);

        // Simultaneous halt and resume in IDLE: halt wins, no resume strobe
        cyc("both_cmd",  1, 1, 1, 0, 0, 32'h0, O_REQ, 32'h77);
        cyc("both_hold", 1, 0, 0, 0, 0, 32'h0, O_REQ, 32'h77);

        // Synchronous reset mid-REQ, then a fresh halt
        cyc("rst_mid",  0, 0, 0, 0, 0, 32'h0,   O_IDLE, 32'h0);
        cyc("post_rst", 1, 0, 0, 0, 0, 32'h0,   O_IDLE, 32'h0);
        cyc("rh_req",   1, 1, 0, 0, 0, 32'h0,   O_REQ,  32'h0);
        cyc("rh_halt",  1, 0, 0, 0, 1, 32'h340, O_HLT,  32'h340);
        cyc("rh_drop",  1, 0, 0, 0, 0, 32'h0,   O_IDLE, 32'h340);

        // Core already in debug mode: REQ lasts one cycle
        cyc("pre_dm",   1, 0, 0, 0, 1, 32'h55, O_IDLE, 32'h340);
        cyc("pre_req",  1, 1, 0, 0, 1, 32'h55, O_REQ,  32'h340);
        cyc("pre_halt", 1, 0, 0, 0, 1, 32'h58, O_HLT,  32'h58);

        // Resume timeout: core never leaves debug mode
        cyc("rto_strobe", 1, 0, 1, 0, 1, 32'h58, O_RSP, 32'h58);
        for (int i = 1; i < int'(T_CYC); i++)
            cyc("rto_hold", 1, 0, 0, 0, 1, 32'h58, O_RES, 32'h58);
        cyc("rto_err",   1, 0, 0, 0, 1, 32'h58, O_ERR,  32'h58);
        cyc("rto_clear", 1, 0, 0, 1, 1, 32'h58, O_IDLE, 32'h58);

        @(posedge clk);
        #3;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dbg_req_ctrl.md
# dbg_req_ctrl

Debug-request initiator that drives the core's `debug_req_i` pin and tracks the core's response. The SoC's fault-tolerance/checkpoint logic issues halt and resume commands to this block, and it handles the core-side handshake. It sits between that logic and the core:
- holds `debug_req` until the core reports debug mode;
- captures the halt PC;
- issues the resume strobe;
- flags any core that fails to respond within a bounded time.

## Interface
- `TIMEOUT_CYCLES`, 64: maximum cycles to wait for the core in REQ or RESUME; valid range ≥ 1.
- `ADDR_WIDTH`, 32: width of the instruction address.
- `clk_i` input 1: clock.
- `rst_ni` input 1: reset, synchronous, active-low.
- `halt_req_i` input 1: halt command, sampled each cycle; a level or a pulse both work.
- `resume_req_i` input 1: resume command, sampled each cycle.
- `clear_i` input 1: clears the ERR state.
- `core_debug_mode_i` input 1: the core is in debug mode.
- `core_instr_addr_i` input ADDR_WIDTH: the core's current instruction address.
- `debug_req_o` output 1: debug request to the core.
- `core_resume_o` output 1: one-cycle resume strobe to the core.
- `busy_o` output 1: high in REQ or RESUME.
- `halted_o` output 1: high in HALTED.
- `timeout_o` output 1: high in ERR.
- `halt_pc_o` output ADDR_WIDTH: address captured on halt entry.

## Operation
- FSM states: IDLE, REQ, HALTED, RESUME, ERR.
- All outputs are registered.
- Reset values: every output is 0, `halt_pc_o` is 0, state is IDLE, counter is 0.
- IDLE:
  - All handshake outputs are low.
  - `halt_req_i`=1 → go to REQ and load the counter with TIMEOUT_CYCLES.
  - `resume_req_i` is ignored.
  - If `halt_req_i` and `resume_req_i` are both high, halt wins.
- REQ:
  - `debug_req_o`=1 and `busy_o`=1.
  - `core_debug_mode_i`=1 → go to HALTED and latch `halt_pc_o` ← `core_instr_addr_i`.
  - Otherwise, counter = 1 → go to ERR; else decrement the counter.
  - Detection takes priority over timeout when both happen in the same cycle.
- HALTED:
  - `halted_o`=1.
  - `halt_req_i` is ignored.
  - `resume_req_i`=1 → go to RESUME, pulse `core_resume_o` for exactly one cycle, reload the counter.
  - `core_debug_mode_i` dropping without a resume → go to IDLE; `halt_pc_o` is retained.
- RESUME:
  - `busy_o`=1.
  - `core_debug_mode_i`=0 → go to IDLE.
  - Otherwise decrement the counter; counter = 1 → go to ERR.
- ERR:
  - `timeout_o`=1 (sticky) and `debug_req_o`=0.
  - `clear_i`=1 → go to IDLE. All other inputs are ignored.
- Counter: width `$clog2(TIMEOUT_CYCLES+1)`; it never wraps because it is reloaded on every REQ/RESUME entry.
- A core already in debug mode when a halt arrives is handled normally: REQ lasts exactly one cycle.
- `halt_pc_o` is updated only on the REQ→HALTED transition.

## Timing
- `halt_req_i` sampled high at edge *t* → `debug_req_o` high after *t*.
- `core_debug_mode_i` sampled high at edge *t* in REQ → after *t*, `halted_o`=1 and `debug_req_o`=0, with `halt_pc_o` valid.
- Timeout (core never responds): `debug_req_o` stays high for exactly TIMEOUT_CYCLES cycles, then `timeout_o` rises.
- `resume_req_i` sampled at edge *t* in HALTED → `core_resume_o` high for the single cycle after *t*.
- Reset is synchronous, so reset mid-operation takes effect at the next rising edge with `rst_ni`=0:
  - `debug_req_o`, `core_resume_o` and all flags drop at that edge;
  - no glitch pulse follows.

## Structure
- Package `dbg_ctrl_pkg` holds:
  - `dbg_state_e` enum (IDLE, REQ, HALTED, RESUME, ERR);
  - the default constants DBG_TIMEOUT_DEF=64 and DBG_ADDR_W=32.
- Optional sub-module `dbg_timeout_cnt`: loadable down-counter with `load_i`, `en_i` and `expire_o`, shared by REQ and RESUME.
- The rest is a single always_ff state/output process plus a next-state always_comb.

## Test plan
- **Normal halt.** Reset, then `halt_req_i` pulse; the core raises debug mode 3 cycles later with addr 0x0000_0120 → `debug_req_o` high for 3 cycles, then `halted_o`=1 and `halt_pc_o`=0x120.
- **Resume.** From HALTED, pulse `resume_req_i`; the core drops debug mode 2 cycles later → `core_resume_o` is a single one-cycle pulse, `busy_o` high for 2 cycles, state ends in IDLE.
- **Timeout.** TIMEOUT_CYCLES=8 and the core never responds → `debug_req_o` high for exactly 8 cycles, then `timeout_o`=1. `timeout_o` holds until `clear_i`, after which the state is IDLE.
- **Simultaneous commands.** `halt_req_i` and `resume_req_i` high together in IDLE → REQ is entered and `core_resume_o` stays 0.
- **Reset mid-REQ.** `rst_ni`=0 for one cycle while in REQ → all outputs are 0 after that edge, and a new halt works normally.
- **Core already halted.** `core_debug_mode_i`=1 before the halt request → REQ lasts 1 cycle and `halt_pc_o` is captured correctly.
